pc_fetch_sequencer: RTL and testbench

// - Owns the architectural PC and sequences instruction fetch: issues requests to the

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/program_counter_add.sv | 19 +
 rtl/pc_fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the fetch sequencer
//
// Purpose : FSM state encoding, PC increment and alignment constants, and a
//           misalignment helper used by pc_fetch_sequencer and program_counter_add.
// Ports   : none (package).

package pc_seq_pkg;

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    // Byte distance between consecutive 32-bit instructions.
    localparam int unsigned PC_INCR = 4;

    // Low PC bits that must be zero for a word-aligned instruction address.
    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return |(addr_lsb & PC_ALIGN_MASK);
    endfunction

endpackage

// File: rtl/program_counter_add.sv
// rtl/program_counter_add.sv - PC + 4 incrementer, wraps modulo 2^DWIDTH
//
// Purpose : Produces the sequential successor of a PC. Used for both the
//           fetch-advance path and the Instr_PC_Off output.
// Ports   : pc_i       in  DWIDTH  current PC
//           pc_next_o  out DWIDTH  pc_i + 4 (carry out discarded)

module program_counter_add
    import pc_seq_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] pc_i,
    output logic [DWIDTH-1:0] pc_next_o
);

    assign pc_next_o = pc_i + DWIDTH'(PC_INCR);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - architectural PC owner and instruction fetch sequencer
//
// Purpose : Issues one fetch request at a time to instruction memory, holds the
//           returned word for decode, advances PC+4 on acceptance, applies redirects
//           and discards responses that belong to a redirected-away fetch.
// Ports   : Clk_Core, Rst_Core_N         clock, async active-low reset
//           Stall                        blocks new fetch requests
//           Redirect_Valid/Target        1-cycle PC redirect
//           IMem_Req_Valid/Ready/Addr    fetch request handshake
//           IMem_Rsp_Valid/Data          fetch response
//           Instr_Valid/Ready/Data/PC    instruction handshake to decode
//           Instr_PC_Off                 Instr_PC + 4
//           Misalign_Fault               pulse one cycle after a misaligned redirect

module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                 DWIDTH       = 32,
    parameter logic [DWIDTH-1:0]  RESET_VECTOR = '0
) (
    input  logic              Clk_Core,
    input  logic              Rst_Core_N,
    input  logic              Stall,
    input  logic              Redirect_Valid,
    input  logic [DWIDTH-1:0] Redirect_Target,
    output logic              IMem_Req_Valid,
    input  logic              IMem_Req_Ready,
    output logic [DWIDTH-1:0] IMem_Req_Addr,
    input  logic              IMem_Rsp_Valid,
    input  logic [DWIDTH-1:0] IMem_Rsp_Data,
    output logic              Instr_Valid,
    input  logic              Instr_Ready,
    output logic [DWIDTH-1:0] Instr_Data,
    output logic [DWIDTH-1:0] Instr_PC,
    output logic [DWIDTH-1:0] Instr_PC_Off,
    output logic              Misalign_Fault
);

    localparam logic [DWIDTH-1:0] ALIGN_CLEAR = ~{{(DWIDTH-2){1'b0}}, PC_ALIGN_MASK};

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] instr_data_q, instr_data_d;
    logic [DWIDTH-1:0] instr_pc_q, instr_pc_d;
    logic              fault_q, fault_d;

    logic [DWIDTH-1:0] pc_plus4;
    logic [DWIDTH-1:0] instr_pc_plus4;
    logic [DWIDTH-1:0] redirect_pc;
    logic              redirect_take;
    logic              req_valid;

    program_counter_add #(.DWIDTH(DWIDTH)) u_pc_advance (
        .pc_i      (pc_q),
        .pc_next_o (pc_plus4)
    );

    program_counter_add #(.DWIDTH(DWIDTH)) u_instr_pc_off (
        .pc_i      (instr_pc_q),
        .pc_next_o (instr_pc_plus4)
    );

    // A misaligned target is force-aligned; the fault is reported separately.
    assign redirect_pc   = Redirect_Target & ALIGN_CLEAR;
    // The boot cycle has no architectural PC in flight yet, so redirects wait.
    assign redirect_take = Redirect_Valid && (state_q != S_BOOT);
    assign req_valid     = (state_q == S_FETCH) && !Stall && !Redirect_Valid;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_data_d = instr_data_q;
        instr_pc_d   = instr_pc_q;
        fault_d      = 1'b0;

        if (redirect_take) begin
            pc_d    = redirect_pc;
            fault_d = is_misaligned(Redirect_Target[1:0]);
        end

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (req_valid && IMem_Req_Ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (Redirect_Valid) begin
                    // Response in the same cycle is stale and dropped; otherwise it
                    // is still in flight and must be drained before refetching.
                    state_d = IMem_Rsp_Valid ? S_FETCH : S_DRAIN;
                end else if (IMem_Rsp_Valid) begin
                    instr_data_d = IMem_Rsp_Data;
                    instr_pc_d   = pc_q;
                    state_d      = S_HOLD;
                end
            end
            S_DRAIN: begin
                if (IMem_Rsp_Valid) begin
                    state_d = S_FETCH;
                end
            end
            S_HOLD: begin
                if (Redirect_Valid) begin
                    state_d = S_FETCH;
                end else if (Instr_Ready) begin
                    pc_d    = pc_plus4;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge Clk_Core or negedge Rst_Core_N) begin
        if (!Rst_Core_N) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_VECTOR;
            instr_data_q <= '0;
            instr_pc_q   <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_data_q <= instr_data_d;
            instr_pc_q   <= instr_pc_d;
            fault_q      <= fault_d;
        end
    end

    assign IMem_Req_Valid = req_valid;
    assign IMem_Req_Addr  = pc_q;
    assign Instr_Valid    = (state_q == S_HOLD);
    assign Instr_Data     = instr_data_q;
    assign Instr_PC       = instr_pc_q;
    // Gated so the output reads 0 out of reset rather than RESET-time PC + 4.
    assign Instr_PC_Off   = (state_q == S_HOLD) ? instr_pc_plus4 : '0;
    assign Misalign_Fault = fault_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - directed self-checking bench for pc_fetch_sequencer

module tb_pc_fetch_sequencer;

    logic        Clk_Core = 1'b0;
    logic        Rst_Core_N;
    logic        Stall;
    logic        Redirect_Valid;
    logic [31:0] Redirect_Target;
    logic        IMem_Req_Valid;
    logic        IMem_Req_Ready;
    logic [31:0] IMem_Req_Addr;
    logic        IMem_Rsp_Valid;
    logic [31:0] IMem_Rsp_Data;
    logic        Instr_Valid;
    logic        Instr_Ready;
    logic [31:0] Instr_Data;
    logic [31:0] Instr_PC;
    logic [31:0] Instr_PC_Off;
    logic        Misalign_Fault;

    int checks = 0;
    int errors = 0;

    always #5 Clk_Core = ~Clk_Core;

    pc_fetch_sequencer #(.DWIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .Clk_Core        (Clk_Core),
        .Rst_Core_N      (Rst_Core_N),
        .Stall           (Stall),
        .Redirect_Valid  (Redirect_Valid),
        .Redirect_Target (Redirect_Target),
        .IMem_Req_Valid  (IMem_Req_Valid),
        .IMem_Req_Ready  (IMem_Req_Ready),
        .IMem_Req_Addr   (IMem_Req_Addr),
        .IMem_Rsp_Valid  (IMem_Rsp_Valid),
        .IMem_Rsp_Data   (IMem_Rsp_Data),
        .Instr_Valid     (Instr_Valid),
        .Instr_Ready     (Instr_Ready),
        .Instr_Data      (Instr_Data),
        .Instr_PC        (Instr_PC),
        .Instr_PC_Off    (Instr_PC_Off),
        .Misalign_Fault  (Misalign_Fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk_Core);
        #2;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"},   32'(IMem_Req_Valid), 32'd0);
        chk({tag, "_req_addr"},    IMem_Req_Addr,       32'h0);
        chk({tag, "_instr_valid"}, 32'(Instr_Valid),    32'd0);
        chk({tag, "_instr_data"},  Instr_Data,          32'h0);
        chk({tag, "_instr_pc"},    Instr_PC,            32'h0);
        chk({tag, "_pc_off"},      Instr_PC_Off,        32'h0);
        chk({tag, "_fault"},       32'(Misalign_Fault), 32'd0);
    endtask

    // Entry: FETCH state. Exit: HOLD state presenting the word.
    task automatic to_hold(input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] exp_off);
        #1;
        chk("req_valid", 32'(IMem_Req_Valid), 32'd1);
        chk("req_addr",  IMem_Req_Addr,       addr);
        tick();
        chk("wait_req_valid",   32'(IMem_Req_Valid), 32'd0);
        chk("wait_instr_valid", 32'(Instr_Valid),    32'd0);
        IMem_Rsp_Valid = 1'b1;
        IMem_Rsp_Data  = data;
        tick();
        IMem_Rsp_Valid = 1'b0;
        IMem_Rsp_Data  = 32'h0;
        #1;
        chk("hold_valid",  32'(Instr_Valid), 32'd1);
        chk("hold_data",   Instr_Data,       data);
        chk("hold_pc",     Instr_PC,         addr);
        chk("hold_pc_off", Instr_PC_Off,     exp_off);
    endtask

    task automatic accept();
        Instr_Ready = 1'b1;
        tick();
        Instr_Ready = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        Rst_Core_N      = 1'b0;
        Stall           = 1'b0;
        Redirect_Valid  = 1'b0;
        Redirect_Target = 32'h0;
        IMem_Req_Ready  = 1'b1;
        IMem_Rsp_Valid  = 1'b0;
        IMem_Rsp_Data   = 32'h0;
        Instr_Ready     = 1'b0;

        // Reset state
        #2;
        check_reset_outputs("rst");
        tick();
        Rst_Core_N = 1'b1;
        #1;
        chk("boot_req_valid", 32'(IMem_Req_Valid), 32'd0);
        tick();

        // Sequential fetch 0x0, 0x4, 0x8
        to_hold(32'h0, 32'h0000_0013, 32'h4);
        accept();
        to_hold(32'h4, 32'h0000_0013, 32'h8);
        accept();
        to_hold(32'h8, 32'h00A0_0093, 32'hC);

        // Decode back-pressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid",     32'(Instr_Valid),    32'd1);
            chk("bp_data",      Instr_Data,          32'h00A0_0093);
            chk("bp_pc",        Instr_PC,            32'h8);
            chk("bp_req_valid", 32'(IMem_Req_Valid), 32'd0);
        end
        accept();

        // Redirect 0x100 in WAIT; stale response 2 cycles later
        #1;
        chk("r1_req_addr", IMem_Req_Addr, 32'hC);
        tick();
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h100;
        tick();
        Redirect_Valid  = 1'b0;
        #1;
        chk("drain_instr_valid", 32'(Instr_Valid),    32'd0);
        chk("drain_req_valid",   32'(IMem_Req_Valid), 32'd0);
        chk("drain_fault",       32'(Misalign_Fault), 32'd0);
        tick();
        IMem_Rsp_Valid = 1'b1;
        IMem_Rsp_Data  = 32'h0000_DEAD;
        tick();
        IMem_Rsp_Valid = 1'b0;
        IMem_Rsp_Data  = 32'h0;
        #1;
        chk("post_drain_instr_valid", 32'(Instr_Valid), 32'd0);
        to_hold(32'h100, 32'h0000_0013, 32'h104);

        // Redirect 0x200 together with Instr_Ready in HOLD
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h200;
        Instr_Ready     = 1'b1;
        tick();
        Redirect_Valid  = 1'b0;
        Instr_Ready     = 1'b0;
        #1;
        chk("hold_redir_valid", 32'(IMem_Req_Valid), 32'd1);
        chk("hold_redir_addr",  IMem_Req_Addr,       32'h200);

        // Misaligned redirect 0x102, then Stall for 4 cycles
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h102;
        #1;
        chk("redir_blocks_req", 32'(IMem_Req_Valid), 32'd0);
        tick();
        Redirect_Valid = 1'b0;
        Stall          = 1'b1;
        #1;
        chk("mis_fault_pulse", 32'(Misalign_Fault), 32'd1);
        chk("mis_addr",        IMem_Req_Addr,       32'h100);
        chk("stall_req_valid", 32'(IMem_Req_Valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_fault_clr", 32'(Misalign_Fault), 32'd0);
            chk("stall_req_valid", 32'(IMem_Req_Valid), 32'd0);
            chk("stall_addr",      IMem_Req_Addr,       32'h100);
        end
        Stall = 1'b0;
        to_hold(32'h100, 32'h0000_0033, 32'h104);
        accept();

        // PC wrap at 0xFFFFFFFC
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'hFFFF_FFFC;
        tick();
        Redirect_Valid  = 1'b0;
        to_hold(32'hFFFF_FFFC, 32'h0000_0073, 32'h0);
        accept();
        #1;
        chk("wrap_req_addr",  IMem_Req_Addr,       32'h0);
        chk("wrap_req_valid", 32'(IMem_Req_Valid), 32'd1);

        // Reset during WAIT; late response ignored
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h300;
        tick();
        Redirect_Valid  = 1'b0;
        #1;
        chk("pre_rst_addr", IMem_Req_Addr, 32'h300);
        tick();
        Rst_Core_N = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        tick();
        Rst_Core_N     = 1'b1;
        IMem_Rsp_Valid = 1'b1;
        IMem_Rsp_Data  = 32'h0000_0BAD;
        tick();
        IMem_Rsp_Valid = 1'b0;
        IMem_Rsp_Data  = 32'h0;
        #1;
        chk("late_rsp_instr_valid", 32'(Instr_Valid), 32'd0);
        chk("late_rsp_instr_data",  Instr_Data,       32'h0);
        to_hold(32'h0, 32'h0000_0013, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
